// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction codes, debounce states and the
// reversal helper used by both the input decoder and the game core.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    DB_RELEASED     = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_HELD         = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_e;

  // Opposite directions differ only in bit 0 (up<->down, left<->right).
  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/arrow_input_decoder_if.sv
// Board-button / game-core bundle of the arrow input decoder.
// The decoder is the slave; the game core (or bench) is the master.
interface arrow_input_decoder_if #(
  parameter int SEED_W = 26
);
  logic              arrow_up;
  logic              arrow_down;
  logic              arrow_left;
  logic              arrow_right;
  logic              step;
  logic [1:0]        arrow;
  logic [1:0]        dire;
  logic              dir_valid;
  logic [SEED_W-1:0] seed;

  modport master (
    output arrow_up, arrow_down, arrow_left, arrow_right, step,
    input  arrow, dire, dir_valid, seed
  );

  modport slave (
    input  arrow_up, arrow_down, arrow_left, arrow_right, step,
    output arrow, dire, dir_valid, seed
  );
endinterface

// File: rtl/button_debounce.sv
// One board button: 2-flop synchroniser, polarity normalisation and a
// debounce FSM that emits a single-cycle press_evt per accepted press.
module button_debounce
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press_evt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_r;
  logic             pressed_s;
  db_state_e        state_r;
  db_state_e        state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Synchroniser clears to the pin's idle level so reset never looks like a press
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= {2{ACTIVE_LOW}};
    end else begin
      sync_r <= {sync_r[0], raw};
    end
  end

  assign pressed_s = sync_r[1] ^ ACTIVE_LOW;

  // Debounce state and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= DB_RELEASED;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; the counter stops at CNT_LAST, so it cannot wrap
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    press_evt   = 1'b0;
    case (state_r)
      DB_RELEASED: begin
        cnt_nxt_s = '0;
        if (pressed_s) begin
          state_nxt_s = DB_PRESS_WAIT;
        end else begin
          state_nxt_s = DB_RELEASED;
        end
      end
      DB_PRESS_WAIT: begin
        if (!pressed_s) begin
          state_nxt_s = DB_RELEASED;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = DB_HELD;
          cnt_nxt_s   = '0;
          press_evt   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      DB_HELD: begin
        cnt_nxt_s = '0;
        if (!pressed_s) begin
          state_nxt_s = DB_RELEASE_WAIT;
        end else begin
          state_nxt_s = DB_HELD;
        end
      end
      DB_RELEASE_WAIT: begin
        if (pressed_s) begin
          state_nxt_s = DB_HELD;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = DB_RELEASED;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = DB_RELEASED;
        cnt_nxt_s   = '0;
      end
    endcase
  end

endmodule

// File: rtl/arrow_input_decoder.sv
// Converts four raw arrow buttons into a pending direction for the snake
// core, rejecting reversals and harvesting press timing into a PRNG seed.
module arrow_input_decoder
  import snake_pkg::*;
#(
  parameter int                DEBOUNCE_CYCLES = 100_000,
  parameter int                SEED_W          = 26,
  parameter logic [SEED_W-1:0] SEED_INIT       = SEED_W'(26'h155_5555)
) (
  input  logic                  clk,
  input  logic                  reset,
  arrow_input_decoder_if.slave  bus
);

  logic [3:0]        evt_s;
  logic [1:0]        cand_s;
  logic [1:0]        ref_s;
  logic              accept_s;
  logic [SEED_W-1:0] seed_mix_s;

  logic [1:0]        arrow_r;
  logic [1:0]        dire_r;
  logic              dir_valid_r;
  logic [SEED_W-1:0] seed_r;
  logic [SEED_W-1:0] free_cnt_r;

  // evt_s is indexed by direction code so the priority order is up > down > left > right
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b1)) u_db_up (
    .clk(clk), .reset(reset), .raw(bus.arrow_up), .press_evt(evt_s[0])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b1)) u_db_down (
    .clk(clk), .reset(reset), .raw(bus.arrow_down), .press_evt(evt_s[1])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b0)) u_db_left (
    .clk(clk), .reset(reset), .raw(bus.arrow_left), .press_evt(evt_s[2])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b0)) u_db_right (
    .clk(clk), .reset(reset), .raw(bus.arrow_right), .press_evt(evt_s[3])
  );

  // Priority pick, reversal check against the direction in force this tick
  always_comb begin
    cand_s = DIR_RIGHT;
    if (evt_s[0]) begin
      cand_s = DIR_UP;
    end else if (evt_s[1]) begin
      cand_s = DIR_DOWN;
    end else if (evt_s[2]) begin
      cand_s = DIR_LEFT;
    end else begin
      cand_s = DIR_RIGHT;
    end
    ref_s      = bus.step ? arrow_r : dire_r;
    accept_s   = (|evt_s) && (cand_s != dir_opposite(ref_s));
    seed_mix_s = seed_r ^ free_cnt_r;
  end

  // Direction registers, free-running counter and seed harvest
  always_ff @(posedge clk) begin
    if (!reset) begin
      arrow_r     <= DIR_UP;
      dire_r      <= DIR_UP;
      dir_valid_r <= 1'b0;
      seed_r      <= SEED_INIT;
      free_cnt_r  <= '0;
    end else begin
      free_cnt_r <= free_cnt_r + SEED_W'(1);
      if (bus.step) begin
        dire_r <= arrow_r;
      end
      if (accept_s && (cand_s != arrow_r)) begin
        arrow_r     <= cand_s;
        dir_valid_r <= 1'b1;
      end else begin
        dir_valid_r <= 1'b0;
      end
      // A zero seed would lock up the PRNG, so fall back to the reset value
      if (|evt_s) begin
        seed_r <= (seed_mix_s == '0) ? SEED_INIT : seed_mix_s;
      end
    end
  end

  assign bus.arrow     = arrow_r;
  assign bus.dire      = dire_r;
  assign bus.dir_valid = dir_valid_r;
  assign bus.seed      = seed_r;

endmodule

// File: tb/tb_arrow_input_decoder.sv
// Directed bench for arrow_input_decoder with a stable-run-length model of
// each button and a per-cycle comparison of all outputs.
module tb_arrow_input_decoder;

  localparam int          DB   = 4;
  localparam int          SW   = 26;
  localparam logic [25:0] INIT = 26'h155_5555;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arrow_input_decoder_if #(.SEED_W(SW)) bus ();

  arrow_input_decoder #(.DEBOUNCE_CYCLES(DB), .SEED_W(SW), .SEED_INIT(INIT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int dv_count = 0;

  // model state: per button synced level pipeline, debounced level, run length
  int          m_s1[4];
  int          m_s2[4];
  int          m_deb[4];
  int          m_run[4];
  int          opp[4] = '{1, 0, 3, 2};
  int          m_arrow;
  int          m_dire;
  int          m_dv;
  logic [25:0] m_seed;
  logic [25:0] m_free;
  bit          model_on = 1'b0;
  logic [25:0] saved_seed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // pressed = 1 regardless of the pin's polarity
  function automatic int norm_btn(input int b);
    case (b)
      0: return (bus.arrow_up    == 1'b0) ? 1 : 0;
      1: return (bus.arrow_down  == 1'b0) ? 1 : 0;
      2: return (bus.arrow_left  == 1'b1) ? 1 : 0;
      default: return (bus.arrow_right == 1'b1) ? 1 : 0;
    endcase
  endfunction

  // Behavioural model: a level is accepted after DB+1 consecutive synced cycles
  initial begin : model
    int winner;
    int refd;
    int new_dire;
    forever begin
      @(posedge clk);
      if (reset === 1'b0) begin
        for (int b = 0; b < 4; b++) begin
          m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_run[b] = 0;
        end
        m_arrow = 0; m_dire = 0; m_dv = 0; m_seed = INIT; m_free = 26'd0;
        model_on = 1'b1;
      end else begin
        winner = -1;
        for (int b = 0; b < 4; b++) begin
          if (m_s2[b] != m_deb[b]) begin
            m_run[b]++;
            if (m_run[b] == DB + 1) begin
              m_deb[b] = m_s2[b];
              m_run[b] = 0;
              if (m_deb[b] == 1 && winner < 0) winner = b;
            end
          end else begin
            m_run[b] = 0;
          end
        end
        refd     = (bus.step === 1'b1) ? m_arrow : m_dire;
        new_dire = (bus.step === 1'b1) ? m_arrow : m_dire;
        m_dv = 0;
        if (winner >= 0) begin
          if (winner != opp[refd] && winner != m_arrow) begin
            m_arrow = winner;
            m_dv = 1;
          end
          m_seed = ((m_seed ^ m_free) == 26'd0) ? INIT : (m_seed ^ m_free);
        end
        m_dire = new_dire;
        m_free = m_free + 26'd1;
        for (int b = 0; b < 4; b++) begin
          m_s2[b] = m_s1[b];
          m_s1[b] = norm_btn(b);
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  initial begin : compare
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("arrow", 32'(bus.arrow), 32'(m_arrow));
        check("dire", 32'(bus.dire), 32'(m_dire));
        check("dir_valid", 32'(bus.dir_valid), 32'(m_dv));
        check("seed", 32'(bus.seed), 32'(m_seed));
        if (bus.dir_valid === 1'b1) dv_count++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.arrow_up = 1'b1; bus.arrow_down = 1'b1;
    bus.arrow_left = 1'b0; bus.arrow_right = 1'b0;
    bus.step = 1'b0;
    reset = 1'b0;
    tick(3);
    reset = 1'b1;

    // idle after reset
    tick(20);
    at_neg;
    check("idle_arrow", 32'(bus.arrow), 32'd0);
    check("idle_dire", 32'(bus.dire), 32'd0);
    check("idle_seed", 32'(bus.seed), 32'h155_5555);
    check("idle_dv", 32'(dv_count), 32'd0);

    // short glitch on right is filtered
    bus.arrow_right = 1'b1;
    tick(2);
    bus.arrow_right = 1'b0;
    tick(10);
    at_neg;
    check("glitch_arrow", 32'(bus.arrow), 32'd0);
    check("glitch_seed", 32'(bus.seed), 32'h155_5555);

    // held right: dir_valid at the 7th edge after the pin change
    tick(1);
    bus.arrow_right = 1'b1;
    tick(6);
    at_neg;
    check("right_edge6_dv", 32'(bus.dir_valid), 32'd0);
    check("right_edge6_arrow", 32'(bus.arrow), 32'd0);
    tick(1);
    at_neg;
    check("right_edge7_dv", 32'(bus.dir_valid), 32'd1);
    check("right_edge7_arrow", 32'(bus.arrow), 32'd3);
    tick(2);
    bus.arrow_right = 1'b0;
    tick(12);
    check("right_dv_once", 32'(dv_count), 32'd1);

    // up is accepted (ref = dire = up), then commit
    bus.arrow_up = 1'b0;
    tick(9);
    bus.arrow_up = 1'b1;
    tick(12);
    check("up_arrow", 32'(bus.arrow), 32'd0);
    bus.step = 1'b1;
    tick(1);
    bus.step = 1'b0;
    tick(2);
    check("commit_dire_up", 32'(bus.dire), 32'd0);

    // down reverses committed up: rejected, but seed still harvested
    saved_seed = m_seed;
    bus.arrow_down = 1'b0;
    tick(9);
    bus.arrow_down = 1'b1;
    tick(12);
    check("down_rej_arrow", 32'(bus.arrow), 32'd0);
    check("down_rej_dv", 32'(dv_count), 32'd2);
    check("down_rej_seed_moved", 32'(bus.seed != saved_seed), 32'd1);

    // left, commit so dire = left, then left+up together: up wins
    bus.arrow_left = 1'b1;
    tick(9);
    bus.arrow_left = 1'b0;
    tick(12);
    check("left_arrow", 32'(bus.arrow), 32'd2);
    bus.step = 1'b1;
    tick(1);
    bus.step = 1'b0;
    tick(2);
    check("commit_dire_left", 32'(bus.dire), 32'd2);
    bus.arrow_up = 1'b0;
    bus.arrow_left = 1'b1;
    tick(9);
    bus.arrow_up = 1'b1;
    bus.arrow_left = 1'b0;
    tick(12);
    check("prio_arrow", 32'(bus.arrow), 32'd0);
    check("prio_dv", 32'(dv_count), 32'd4);

    // arrow = up, dire = left: right alone would reverse dire, but a step in
    // the event cycle makes ref = arrow, so right is accepted
    bus.arrow_right = 1'b1;
    tick(6);
    bus.step = 1'b1;
    tick(1);
    bus.step = 1'b0;
    at_neg;
    check("step_right_arrow", 32'(bus.arrow), 32'd3);
    check("step_right_dire", 32'(bus.dire), 32'd0);
    check("step_right_dv", 32'(bus.dir_valid), 32'd1);
    tick(3);
    bus.arrow_right = 1'b0;
    tick(12);

    // left held through reset completes a full debounce
    reset = 1'b0;
    bus.arrow_left = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(6);
    at_neg;
    check("rst_hold_edge6_arrow", 32'(bus.arrow), 32'd0);
    check("rst_hold_edge6_dv", 32'(bus.dir_valid), 32'd0);
    tick(1);
    at_neg;
    check("rst_hold_edge7_dv", 32'(bus.dir_valid), 32'd1);
    check("rst_hold_edge7_arrow", 32'(bus.arrow), 32'd2);
    saved_seed = m_seed;

    // bouncing a held button produces no further events
    for (int i = 0; i < 20; i++) begin
      bus.arrow_left = ~bus.arrow_left;
      tick(1);
    end
    bus.arrow_left = 1'b0;
    tick(12);
    check("bounce_dv", 32'(dv_count), 32'd6);
    check("bounce_arrow", 32'(bus.arrow), 32'd2);
    check("bounce_seed", 32'(bus.seed), 32'(saved_seed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
